// File: rtl/cdf_noise_channel_pkg.sv
// Shared types and helpers for the CDF noise channel: FSM encoding, level count, saturating add.
package cdf_noise_channel_pkg;

  localparam logic [1:0] STATE_LOAD  = 2'd0;
  localparam logic [1:0] STATE_CHECK = 2'd1;
  localparam logic [1:0] STATE_RUN   = 2'd2;
  localparam logic [1:0] STATE_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    StLoad  = STATE_LOAD,
    StCheck = STATE_CHECK,
    StRun   = STATE_RUN,
    StDrain = STATE_DRAIN
  } state_e;

  function automatic int unsigned num_levels(input int unsigned mag_bits);
    return 32'd1 << mag_bits;
  endfunction

  // Adds two signed values and clamps to the range of a width-bit two's complement number.
  function automatic int sat_add(input int a, input int b, input int unsigned width);
    int sum;
    int hi;
    int lo;
    sum = a + b;
    hi  = (1 << (width - 1)) - 1;
    lo  = -hi - 1;
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/cdf_noise_channel_if.sv
// Ready/valid stream bundle used on both sides of the noise channel.
interface cdf_noise_channel_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/cdf_search_stage.sv
// One binary-search step of the inverse-CDF lookup: decides bit BIT of the level index.
module cdf_search_stage #(
  parameter int unsigned MAG_BITS          = 6,
  parameter int unsigned PROB_WIDTH        = 64,
  parameter int unsigned SIGNAL_RESOLUTION = 8,
  parameter int unsigned BIT               = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         adv,
  input  logic                         in_valid,
  input  logic [MAG_BITS-1:0]          in_p,
  input  logic [PROB_WIDTH-1:0]        in_rnd,
  input  logic [SIGNAL_RESOLUTION-1:0] in_sym,
  output logic [MAG_BITS-1:0]          rd_addr,
  input  logic [PROB_WIDTH-1:0]        rd_data,
  output logic                         out_valid,
  output logic [MAG_BITS-1:0]          out_p,
  output logic [PROB_WIDTH-1:0]        out_rnd,
  output logic [SIGNAL_RESOLUTION-1:0] out_sym
);
  localparam logic [MAG_BITS-1:0] LOW_MASK = MAG_BITS'((1 << BIT) - 1);

  logic [MAG_BITS-1:0] p_d;

  // Probe the top entry of the lower half still in play.
  assign rd_addr = in_p | LOW_MASK;

  always_comb begin
    p_d = in_p;
    if (in_rnd > rd_data) p_d[BIT] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= in_valid;
      out_p     <= p_d;
      out_rnd   <= in_rnd;
      out_sym   <= in_sym;
    end
  end
endmodule

// File: rtl/urng_64.sv
// Combined three-component 64-bit Tausworthe URNG; rnd reflects the current state, en steps it.
module urng_64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [63:0] seed0,
  input  logic [63:0] seed1,
  input  logic [63:0] seed2,
  output logic [63:0] rnd
);
  logic [63:0] z1_q, z2_q, z3_q;
  logic [63:0] z1_d, z2_d, z3_d;
  logic [63:0] b1, b2, b3;

  always_comb begin
    b1   = ((z1_q << 5) ^ z1_q) >> 39;
    z1_d = ((z1_q & 64'hFFFF_FFFF_FFFF_FFFE) << 24) ^ b1;
    b2   = ((z2_q << 19) ^ z2_q) >> 45;
    z2_d = ((z2_q & 64'hFFFF_FFFF_FFFF_FFC0) << 13) ^ b2;
    b3   = ((z3_q << 24) ^ z3_q) >> 48;
    z3_d = ((z3_q & 64'hFFFF_FFFF_FFFF_FE00) << 7) ^ b3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z1_q <= seed0;
      z2_q <= seed1;
      z3_q <= seed2;
    end else if (en) begin
      z1_q <= z1_d;
      z2_q <= z2_d;
      z3_q <= z3_d;
    end
  end

  assign rnd = z1_q ^ z2_q ^ z3_q;
endmodule

// File: rtl/cdf_noise_channel.sv
// Streaming noise channel: inverse-CDF magnitude lookup, random sign, saturating add to the symbol.
module cdf_noise_channel
  import cdf_noise_channel_pkg::*;
#(
  parameter int unsigned SIGNAL_RESOLUTION = 8,
  parameter int unsigned MAG_BITS          = 6,
  parameter int unsigned PROB_WIDTH        = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [63:0]           rng_seed0,
  input  logic [63:0]           rng_seed1,
  input  logic [63:0]           rng_seed2,
  input  logic                  cfg_we,
  input  logic [MAG_BITS-1:0]   cfg_addr,
  input  logic [PROB_WIDTH-1:0] cfg_data,
  input  logic                  cfg_commit,
  input  logic                  cfg_reload,
  input  logic                  noise_en,
  cdf_noise_channel_if.slave    s_if,
  cdf_noise_channel_if.master   m_if,
  output logic [1:0]            state,
  output logic                  cfg_error,
  output logic [31:0]           sat_count
);
  localparam int unsigned NUM_LEVELS = num_levels(MAG_BITS);
  localparam logic [MAG_BITS-1:0] LAST_CHK = MAG_BITS'(NUM_LEVELS - 2);

  logic [PROB_WIDTH-1:0] prob [NUM_LEVELS];

  state_e                state_q, state_d;
  logic [MAG_BITS-1:0]   chk_idx_q, chk_idx_d, chk_nxt;
  logic                  chk_bad_q, chk_bad_d;
  logic                  cfg_error_q, cfg_error_d;
  logic                  adv, s_ready_w, accept, pipe_busy;
  logic [63:0]           urng_rnd;

  logic                         in_valid_q;
  logic [PROB_WIDTH-1:0]        in_rnd_q;
  logic [SIGNAL_RESOLUTION-1:0] in_sym_q;

  logic                         st_valid [MAG_BITS+1];
  logic [MAG_BITS-1:0]          st_p     [MAG_BITS+1];
  logic [PROB_WIDTH-1:0]        st_rnd   [MAG_BITS+1];
  logic [SIGNAL_RESOLUTION-1:0] st_sym   [MAG_BITS+1];

  logic                         m_valid_q, m_sat_q, out_sat;
  logic [SIGNAL_RESOLUTION-1:0] m_data_q, out_data;
  logic [31:0]                  sat_count_q;
  int                           sym_int, noise_int, sat_res;

  assign adv       = !m_valid_q | m_if.ready;
  assign s_ready_w = (state_q == StRun) & adv;
  assign accept    = s_if.valid & s_ready_w;

  urng_64 u_urng (
    .clk   (clk),
    .rst   (rst),
    .en    (accept),
    .seed0 (rng_seed0),
    .seed1 (rng_seed1),
    .seed2 (rng_seed2),
    .rnd   (urng_rnd)
  );

  always_ff @(posedge clk) begin
    if (state_q == StLoad && cfg_we) prob[cfg_addr] <= cfg_data;
  end

  // In bypass a zero sample resolves to level 0 with positive sign, so no noise is added.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_q <= 1'b0;
    end else if (adv) begin
      in_valid_q <= accept;
      in_rnd_q   <= noise_en ? urng_rnd[PROB_WIDTH-1:0] : '0;
      in_sym_q   <= s_if.data;
    end
  end

  assign st_valid[0] = in_valid_q;
  assign st_p[0]     = '0;
  assign st_rnd[0]   = in_rnd_q;
  assign st_sym[0]   = in_sym_q;

  for (genvar k = 0; k < MAG_BITS; k++) begin : g_stage
    logic [MAG_BITS-1:0] rd_addr;
    cdf_search_stage #(
      .MAG_BITS          (MAG_BITS),
      .PROB_WIDTH        (PROB_WIDTH),
      .SIGNAL_RESOLUTION (SIGNAL_RESOLUTION),
      .BIT               (MAG_BITS - 1 - k)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .adv       (adv),
      .in_valid  (st_valid[k]),
      .in_p      (st_p[k]),
      .in_rnd    (st_rnd[k]),
      .in_sym    (st_sym[k]),
      .rd_addr   (rd_addr),
      .rd_data   (prob[rd_addr]),
      .out_valid (st_valid[k+1]),
      .out_p     (st_p[k+1]),
      .out_rnd   (st_rnd[k+1]),
      .out_sym   (st_sym[k+1])
    );
  end

  always_comb begin
    sym_int   = int'(signed'(st_sym[MAG_BITS]));
    noise_int = st_rnd[MAG_BITS][0] ? -int'(st_p[MAG_BITS]) : int'(st_p[MAG_BITS]);
    sat_res   = sat_add(sym_int, noise_int, SIGNAL_RESOLUTION);
    out_sat   = sat_res != (sym_int + noise_int);
    out_data  = sat_res[SIGNAL_RESOLUTION-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
    end else if (adv) begin
      m_valid_q <= st_valid[MAG_BITS];
      m_data_q  <= out_data;
      m_sat_q   <= out_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count_q <= '0;
    end else if (m_valid_q && m_if.ready && m_sat_q && sat_count_q != '1) begin
      sat_count_q <= sat_count_q + 32'd1;
    end
  end

  always_comb begin
    pipe_busy = m_valid_q;
    for (int unsigned i = 0; i <= MAG_BITS; i++) pipe_busy = pipe_busy | st_valid[i];
  end

  assign chk_nxt = chk_idx_q + MAG_BITS'(1);

  always_comb begin
    state_d     = state_q;
    chk_idx_d   = chk_idx_q;
    chk_bad_d   = chk_bad_q;
    cfg_error_d = cfg_error_q;
    unique case (state_q)
      StLoad: begin
        if (cfg_commit) begin
          state_d   = StCheck;
          chk_idx_d = '0;
          chk_bad_d = 1'b0;
        end
      end
      StCheck: begin
        chk_bad_d = chk_bad_q | (prob[chk_nxt] < prob[chk_idx_q]);
        chk_idx_d = chk_nxt;
        if (chk_idx_q == LAST_CHK) begin
          state_d     = chk_bad_d ? StLoad : StRun;
          cfg_error_d = chk_bad_d;
        end
      end
      StRun: begin
        if (cfg_reload) state_d = StDrain;
      end
      StDrain: begin
        if (!pipe_busy) state_d = StLoad;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLoad;
      chk_idx_q   <= '0;
      chk_bad_q   <= 1'b0;
      cfg_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      chk_idx_q   <= chk_idx_d;
      chk_bad_q   <= chk_bad_d;
      cfg_error_q <= cfg_error_d;
    end
  end

  assign s_if.ready = s_ready_w;
  assign m_if.valid = m_valid_q;
  assign m_if.data  = m_data_q;
  assign state      = state_q;
  assign cfg_error  = cfg_error_q;
  assign sat_count  = sat_count_q;
endmodule

// File: tb/tb_cdf_noise_channel.sv
// Randomised stream bench for cdf_noise_channel against a linear-scan inverse-CDF reference model.
module tb_cdf_noise_channel;
  localparam int NL = 64;
  localparam logic [63:0] SEED0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] SEED1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] SEED2 = 64'h0F1E_2D3C_4B5A_6978;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we, cfg_commit, cfg_reload, noise_en;
  logic [5:0]  cfg_addr;
  logic [63:0] cfg_data;
  logic [1:0]  state;
  logic        cfg_error;
  logic [31:0] sat_count;

  always #5 clk = ~clk;

  cdf_noise_channel_if #(.WIDTH(8)) s_if ();
  cdf_noise_channel_if #(.WIDTH(8)) m_if ();

  cdf_noise_channel #(
    .SIGNAL_RESOLUTION (8),
    .MAG_BITS          (6),
    .PROB_WIDTH        (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rng_seed0  (SEED0),
    .rng_seed1  (SEED1),
    .rng_seed2  (SEED2),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .cfg_reload (cfg_reload),
    .noise_en   (noise_en),
    .s_if       (s_if),
    .m_if       (m_if),
    .state      (state),
    .cfg_error  (cfg_error),
    .sat_count  (sat_count)
  );

  typedef struct {
    logic [7:0] data;
    bit         sat;
  } beat_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] mtbl [NL];
  logic [63:0] mz1, mz2, mz3;
  beat_t       exp_q[$];
  int          exp_sat, beats_in, beats_out, cyc, first_acc, first_mv;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] taus(input logic [63:0] z, input int q, input int s,
                                       input int k);
    logic [63:0] mask;
    mask = ~64'h0 << (64 - k);
    return ((z & mask) << s) ^ (((z << q) ^ z) >> (k - s));
  endfunction

  function automatic void model_seed();
    mz1 = SEED0;
    mz2 = SEED1;
    mz3 = SEED2;
  endfunction

  // Level = smallest i with rnd <= prob[i], capped at the top level.
  function automatic void model_accept(input logic [7:0] sym, input bit en);
    logic [63:0] r;
    int          mag, noise, sum;
    beat_t       b;
    r   = mz1 ^ mz2 ^ mz3;
    mz1 = taus(mz1, 5, 24, 63);
    mz2 = taus(mz2, 19, 13, 58);
    mz3 = taus(mz3, 24, 7, 55);
    mag   = 0;
    noise = 0;
    if (en) begin
      while (mag < NL - 1 && r > mtbl[mag]) mag++;
      noise = r[0] ? -mag : mag;
    end
    sum   = int'($signed(sym)) + noise;
    b.sat = (sum > 127) || (sum < -128);
    if (sum > 127) sum = 127;
    else if (sum < -128) sum = -128;
    b.data = sum[7:0];
    exp_q.push_back(b);
  endfunction

  task automatic step();
    bit    acc, fire;
    beat_t b;
    #1;
    acc  = s_if.valid && s_if.ready;
    fire = m_if.valid && m_if.ready;
    if (m_if.valid && first_mv < 0) first_mv = cyc;
    if (fire) begin
      if (exp_q.size() == 0) begin
        check_eq("beat_queue", 64'(exp_q.size()), 64'd1);
      end else begin
        b = exp_q.pop_front();
        check_eq("m_data", m_if.data, b.data);
        if (b.sat) exp_sat++;
        beats_out++;
      end
    end
    if (acc) begin
      if (first_acc < 0) first_acc = cyc + 1;
      model_accept(s_if.data, noise_en);
      beats_in++;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic write_mtbl();
    for (int i = 0; i < NL; i++) begin
      cfg_we   = 1'b1;
      cfg_addr = 6'(i);
      cfg_data = mtbl[i];
      step();
    end
    cfg_we = 1'b0;
  endtask

  task automatic do_commit(output int n);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    cfg_we     = 1'b0;
    n = 0;
    while (state == 2'd1 && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic do_reload();
    int n;
    s_if.valid  = 1'b0;
    m_if.ready  = 1'b1;
    cfg_reload  = 1'b1;
    step();
    cfg_reload = 1'b0;
    n = 0;
    while (state != 2'd0 && n < 500) begin
      step();
      n++;
    end
    check_eq("drain_to_load", state, 2'd0);
  endtask

  task automatic run_stream(input int n, input int mode, input int stall, input bit rnd_en,
                            input int budget);
    int base, sent, c;
    base      = beats_in;
    c         = 0;
    first_acc = -1;
    first_mv  = -1;
    while (c < budget) begin
      sent = beats_in - base;
      if (sent >= n && exp_q.size() == 0) break;
      s_if.valid = (sent < n) && ($urandom_range(99) >= stall);
      case (mode)
        0:       s_if.data = 8'(sent % 101);
        1:       s_if.data = 8'($urandom);
        default: s_if.data = sent[0] ? 8'h82 : 8'd124;
      endcase
      m_if.ready = $urandom_range(99) >= stall;
      noise_en   = rnd_en ? ($urandom_range(99) >= 20) : 1'b1;
      step();
      c++;
    end
    s_if.valid = 1'b0;
    m_if.ready = 1'b1;
    noise_en   = 1'b1;
    check_eq("stream_done", 64'(c < budget), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int          n, ob;
    logic [63:0] good;
    rst        = 1'b1;
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
    cfg_reload = 1'b0;
    cfg_addr   = '0;
    cfg_data   = '0;
    noise_en   = 1'b1;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    m_if.ready = 1'b1;
    cyc = 0; exp_sat = 0; beats_in = 0; beats_out = 0; first_acc = -1; first_mv = -1;
    @(posedge clk);
    #1;
    step();
    step();
    check_eq("rst_state", state, 2'd0);
    check_eq("rst_m_valid", m_if.valid, 1'b0);
    check_eq("rst_s_ready", s_if.ready, 1'b0);
    check_eq("rst_cfg_error", cfg_error, 1'b0);
    check_eq("rst_sat_count", sat_count, 32'd0);
    rst = 1'b0;
    model_seed();

    // All-ones table: transparent channel, latency check.
    for (int i = 0; i < NL; i++) mtbl[i] = '1;
    write_mtbl();
    do_commit(n);
    check_eq("t1_check_cycles", n, 63);
    check_eq("t1_state_run", state, 2'd2);
    check_eq("t1_cfg_error", cfg_error, 1'b0);
    run_stream(101, 0, 0, 1'b0, 400);
    check_eq("t1_latency", first_mv - first_acc, 7);

    // Magnitude 5 near the rails.
    do_reload();
    for (int i = 0; i < NL; i++) mtbl[i] = (i < 5) ? 64'd0 : '1;
    write_mtbl();
    do_commit(n);
    check_eq("t2_state_run", state, 2'd2);
    run_stream(60, 2, 20, 1'b0, 1000);
    check_eq("t2_sat_count", sat_count, 32'(exp_sat));

    // Non-monotone table rejected, then fixed by a write landing with the commit.
    do_reload();
    for (int i = 0; i < NL; i++) mtbl[i] = 64'(i + 1) << 57;
    good    = mtbl[3];
    mtbl[3] = '0;
    write_mtbl();
    do_commit(n);
    check_eq("t3_check_cycles", n, 63);
    check_eq("t3_state_load", state, 2'd0);
    check_eq("t3_cfg_error", cfg_error, 1'b1);
    s_if.valid = 1'b1;
    check_eq("t3_s_ready", s_if.ready, 1'b0);
    s_if.valid = 1'b0;
    mtbl[3]  = good;
    cfg_we   = 1'b1;
    cfg_addr = 6'd3;
    cfg_data = good;
    do_commit(n);
    check_eq("t3_recheck_cycles", n, 63);
    check_eq("t3_state_run", state, 2'd2);
    check_eq("t3_cfg_error_clr", cfg_error, 1'b0);

    // Long randomised stream with stalls and bypass.
    run_stream(10000, 1, 30, 1'b1, 60000);
    check_eq("t4_sat_count", sat_count, 32'(exp_sat));
    check_eq("t4_sat_nonzero", 64'(sat_count != 0), 64'd1);

    // Reset mid-stream, then replay from the seeds with the retained table.
    s_if.valid = 1'b1;
    m_if.ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_if.data = 8'($urandom);
      step();
    end
    s_if.valid = 1'b0;
    m_if.ready = 1'b0;
    rst = 1'b1;
    step();
    check_eq("t5_m_valid", m_if.valid, 1'b0);
    check_eq("t5_sat_count", sat_count, 32'd0);
    check_eq("t5_state", state, 2'd0);
    rst        = 1'b0;
    m_if.ready = 1'b1;
    exp_q.delete();
    exp_sat = 0;
    model_seed();
    do_commit(n);
    check_eq("t5_state_run", state, 2'd2);
    run_stream(50, 1, 10, 1'b0, 1000);
    check_eq("t5_sat_after", sat_count, 32'(exp_sat));

    // Reload with five beats in flight.
    ob = beats_out;
    s_if.valid = 1'b1;
    m_if.ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_if.data = 8'($urandom);
      step();
    end
    s_if.valid = 1'b0;
    cfg_reload = 1'b1;
    step();
    cfg_reload = 1'b0;
    check_eq("t6_state_drain", state, 2'd3);
    s_if.valid = 1'b1;
    check_eq("t6_s_ready", s_if.ready, 1'b0);
    n = 0;
    while (state != 2'd0 && n < 50) begin
      step();
      n++;
    end
    s_if.valid = 1'b0;
    check_eq("t6_state_load", state, 2'd0);
    check_eq("t6_beats_out", beats_out - ob, 5);
    check_eq("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    // Writes while running must not reach the table.
    do_commit(n);
    check_eq("t6_state_run", state, 2'd2);
    for (int i = 0; i < NL; i++) begin
      cfg_we   = 1'b1;
      cfg_addr = 6'(i);
      cfg_data = '0;
      step();
    end
    cfg_we = 1'b0;
    run_stream(300, 1, 20, 1'b0, 2000);
    check_eq("t6_sat_count", sat_count, 32'(exp_sat));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
